// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the CDC FIFO read-side drain controller:
// default lane/word/counter widths and the controller state encoding.
package fifo_rd_stream_pkg;

  localparam int DEF_BW   = 20;  // bits per lane
  localparam int DEF_SIMD = 1;   // lanes per word
  localparam int DEF_CW   = 16;  // frame length / word counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO-head and downstream stream signals of the read-side drain controller.
//
// Handshakes:
//  - FIFO side: fifo_rdata is the combinational FIFO head, meaningful only while
//    !fifo_empty. The FIFO advances on rd_clk when fifo_rd && !fifo_empty.
//  - Stream side: a word transfers on every rd_clk edge where o_valid && o_ready.
//    Once o_valid is high, o_data/o_last hold until that transfer; o_valid never
//    depends combinationally on o_ready. o_last is meaningful only with o_valid.
interface fifo_rd_stream_if #(
  parameter int DW = 20
);
  logic [DW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_ready;
  logic          o_last;

  // Drain controller side.
  modport master (
    input  fifo_rdata, fifo_empty, o_ready,
    output fifo_rd, o_data, o_valid, o_last
  );

  // FIFO and downstream consumer side.
  modport slave (
    output fifo_rdata, fifo_empty, o_ready,
    input  fifo_rd, o_data, o_valid, o_last
  );
endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// Two-entry registered buffer between the FIFO head and the output stream.
// Entry 0 is always the head; a pop shifts entry 1 forward. The caller only
// pushes while cnt < 2 and only pops while cnt != 0.
module fifo_rd_stream_skid_buf #(
  parameter int DW = 20
) (
  input  logic          rd_clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [1:0]    cnt
);

  logic [DW-1:0] ent0_q;
  logic [DW-1:0] ent1_q;
  logic [1:0]    cnt_q;

  // Entry storage and occupancy; simultaneous push+pop keeps the count and order.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= din;
          else               ent1_q <= din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_q <= din;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain controller for the dual-clock FIFO (rd_clk domain only).
// Each accepted start pulse drains frame_len words from the FIFO head through a
// two-entry registered buffer and presents them as a valid/ready stream with
// o_last on the final word, then pulses done for one cycle.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int bw   = DEF_BW,
  parameter int simd = DEF_SIMD,
  parameter int CW   = DEF_CW
) (
  input  logic                rd_clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CW-1:0]       frame_len,
  fifo_rd_stream_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       word_cnt,
  output state_t              dbg_state
);

  localparam int DW = simd * bw;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] len_q;
  logic [CW-1:0] issued_q;
  logic [CW-1:0] word_cnt_q;
  logic [CW-1:0] len_m1;
  logic [1:0]    buf_cnt;
  logic [DW-1:0] buf_head;
  logic          start_ok;
  logic          pop_fifo;
  logic          beat;
  logic          o_valid_int;
  logic          o_last_int;

  // Start is only honoured from IDLE, so pulses while busy (including DONE) drop.
  assign start_ok = (state_q == ST_IDLE) && start;

  // Pop decision uses only registered state and the FIFO flag, never o_ready.
  assign pop_fifo = (state_q == ST_RUN) && !bus.fifo_empty &&
                    (issued_q != len_q) && (buf_cnt < 2'd2);

  assign o_valid_int = (buf_cnt != 2'd0);
  assign beat        = o_valid_int && bus.o_ready;
  assign len_m1      = len_q - CNT_ONE;
  assign o_last_int  = o_valid_int && (word_cnt_q == len_m1);

  assign bus.fifo_rd = pop_fifo;
  assign bus.o_valid = o_valid_int;
  assign bus.o_data  = buf_head;
  assign bus.o_last  = o_last_int;

  fifo_rd_stream_skid_buf #(
    .DW (DW)
  ) u_buf (
    .rd_clk (rd_clk),
    .reset  (reset),
    .push   (pop_fifo),
    .pop    (beat),
    .din    (bus.fifo_rdata),
    .head   (buf_head),
    .cnt    (buf_cnt)
  );

  // State register.
  always_ff @(posedge rd_clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: zero-length frames go straight to DONE without touching the FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (frame_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (beat && o_last_int) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame length latch plus issued-pop and delivered-word counters.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      len_q      <= '0;
      issued_q   <= '0;
      word_cnt_q <= '0;
    end else if (start_ok) begin
      len_q      <= frame_len;
      issued_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      if (pop_fifo) issued_q   <= issued_q + CNT_ONE;
      if (beat)     word_cnt_q <= word_cnt_q + CNT_ONE;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign word_cnt  = word_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a small FIFO model feeds the head, a table of frames
// is driven and scoreboarded, plus directed sequences for zero-length frames and
// reset in the middle of a frame.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  localparam int CW = 16;
  localparam int DW = 20;

  // ---------------- clock / reset ----------------
  logic rd_clk = 1'b0;
  logic reset;
  always #5 rd_clk = ~rd_clk;

  logic          start;
  logic [CW-1:0] frame_len;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_cnt;
  state_t        dbg_state;

  fifo_rd_stream_if #(.DW(DW)) ifc ();

  fifo_rd_stream #(.bw(20), .simd(1), .CW(CW)) dut (
    .rd_clk    (rd_clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .bus       (ifc.master),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- FIFO model ----------------
  logic [DW-1:0] fifo_mem [0:255];
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr = 8'd0;
  logic          hold_empty;
  logic          fifo_flush;

  assign ifc.fifo_rdata = fifo_mem[rd_ptr];
  assign ifc.fifo_empty = hold_empty || (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (fifo_flush)                             rd_ptr <= wr_ptr;
    else if (ifc.fifo_rd && !ifc.fifo_empty)    rd_ptr <= rd_ptr + 8'd1;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            tests_run    = 0;
  int            tests_failed = 0;
  int            pops, beats;
  logic          prev_valid, prev_ready, prev_pop, last_beat, saw_drop;
  logic [DW-1:0] prev_data, last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observe the cycle just before the active edge.
  task automatic sample();
    logic [DW-1:0] e;
    check("rd_on_empty", {63'd0, ifc.fifo_rd & ifc.fifo_empty}, 64'd0);
    if (prev_pop) check("head_to_valid_latency", {63'd0, ifc.o_valid}, 64'd1);
    if (prev_valid && !prev_ready) begin
      check("stall_valid", {63'd0, ifc.o_valid}, 64'd1);
      check("stall_data", {44'd0, ifc.o_data}, {44'd0, prev_data});
    end
    if (hold_empty && !ifc.o_valid) saw_drop = 1'b1;
    prev_pop = ifc.fifo_rd && !ifc.fifo_empty;
    if (prev_pop) pops++;
    if (ifc.o_valid && ifc.o_ready) begin
      beats++;
      check("beat_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("o_data", {44'd0, ifc.o_data}, {44'd0, e});
        check("o_last", {63'd0, ifc.o_last}, {63'd0, exp_q.size() == 0});
        last_data = ifc.o_data;
        if (ifc.o_last) last_beat = 1'b1;
      end
    end else begin
      check("o_last_idle", {63'd0, ifc.o_last & ~ifc.o_valid}, 64'd0);
    end
    check("occupancy_le_2", {63'd0, (pops - beats) <= 2}, 64'd1);
    prev_valid = ifc.o_valid;
    prev_ready = ifc.o_ready;
    prev_data  = ifc.o_data;
  endtask

  task automatic cycle();
    @(negedge rd_clk);
    sample();
    @(posedge rd_clk);
    #1;
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    logic [CW-1:0] len;
    bit            ready_toggle;
    int            gap_after;
    int            gap_len;
    int            restart_cyc;
    logic [CW-1:0] restart_len;
    bit            start_on_done;
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    logic [CW-1:0] exp_words;
    logic [DW-1:0] exp_last;
    bit            exp_drop;
  } frame_vec_t;

  frame_vec_t vecs [6];

  task automatic load_frame(input frame_vec_t v);
    logic [DW-1:0] d;
    d = v.base;
    for (int i = 0; i < int'(v.len); i++) begin
      fifo_mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 8'd1;
      exp_q.push_back(d);
      d = d + v.step;
    end
    // Guard word: any pop beyond the frame length would consume it.
    fifo_mem[wr_ptr] = 20'h5A5A5;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic run_frame(input frame_vec_t v);
    bit finished;
    int gap_cnt;
    load_frame(v);
    pops = 0; beats = 0; last_beat = 1'b0; saw_drop = 1'b0; gap_cnt = 0; finished = 1'b0;
    start = 1'b1; frame_len = v.len; ifc.o_ready = 1'b1;
    cycle();
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    for (int c = 0; c < 200 && !finished; c++) begin
      ifc.o_ready = v.ready_toggle ? ((c % 2) == 0) : 1'b1;
      if (v.gap_len > 0 && pops >= v.gap_after && gap_cnt < v.gap_len) begin
        hold_empty = 1'b1;
        gap_cnt++;
      end else begin
        hold_empty = 1'b0;
      end
      start = (c == v.restart_cyc);
      if (c == v.restart_cyc) frame_len = v.restart_len;
      cycle();
      start = 1'b0;
      if (last_beat) begin
        check("done_pulse", {63'd0, done}, 64'd1);
        check("word_cnt_final", {48'd0, word_cnt}, {48'd0, v.exp_words});
        check("last_data", {44'd0, last_data}, {44'd0, v.exp_last});
        check("exp_q_drained", exp_q.size(), 64'd0);
        check("o_valid_at_done", {63'd0, ifc.o_valid}, 64'd0);
        finished = 1'b1;
      end else begin
        check("done_early", {63'd0, done}, 64'd0);
      end
    end
    check("frame_finished", {63'd0, finished}, 64'd1);
    if (v.exp_drop) check("o_valid_dropped_in_gap", {63'd0, saw_drop}, 64'd1);
    hold_empty = 1'b0;
    ifc.o_ready = 1'b1;
    if (v.start_on_done) begin
      start = 1'b1;
      frame_len = 16'd7;
    end
    fifo_flush = 1'b1;
    cycle();
    start = 1'b0;
    fifo_flush = 1'b0;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("state_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check("pop_count", pops, {48'd0, v.exp_words});
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    frame_vec_t v;
    reset = 1'b1; start = 1'b0; frame_len = '0; ifc.o_ready = 1'b0;
    hold_empty = 1'b0; fifo_flush = 1'b0; wr_ptr = 8'd0;
    pops = 0; beats = 0; prev_valid = 1'b0; prev_ready = 1'b0; prev_pop = 1'b0;
    prev_data = '0; last_data = '0; last_beat = 1'b0; saw_drop = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1;

    // Reset state.
    check("rst_o_valid", {63'd0, ifc.o_valid}, 64'd0);
    check("rst_o_last", {63'd0, ifc.o_last}, 64'd0);
    check("rst_o_data", {44'd0, ifc.o_data}, 64'd0);
    check("rst_fifo_rd", {63'd0, ifc.fifo_rd}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_word_cnt", {48'd0, word_cnt}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    reset = 1'b0;
    cycle();

    //          len  tog gapA gapL rcyc rlen sod base      step    words last      drop
    vecs[0] = '{16'd4, 1'b0, 0, 0, -1, 16'd0, 1'b0, 20'h00011, 20'h11, 16'd4, 20'h00044, 1'b0};
    vecs[1] = '{16'd8, 1'b1, 0, 0, -1, 16'd0, 1'b0, 20'h00100, 20'h01, 16'd8, 20'h00107, 1'b0};
    vecs[2] = '{16'd6, 1'b0, 2, 5, -1, 16'd0, 1'b0, 20'h00200, 20'h03, 16'd6, 20'h0020F, 1'b1};
    vecs[3] = '{16'd1, 1'b0, 0, 0, -1, 16'd0, 1'b1, 20'hABCDE, 20'h00, 16'd1, 20'hABCDE, 1'b0};
    vecs[4] = '{16'd5, 1'b1, 4, 3, -1, 16'd0, 1'b0, 20'hFFFFE, 20'h01, 16'd5, 20'h00002, 1'b0};
    vecs[5] = '{16'd3, 1'b1, 0, 0,  1, 16'd9, 1'b0, 20'h00300, 20'h07, 16'd3, 20'h0030E, 1'b0};

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Zero-length frame: no pops even with data waiting, done the next cycle.
    fifo_mem[wr_ptr] = 20'h55555;
    wr_ptr = wr_ptr + 8'd1;
    pops = 0; beats = 0;
    start = 1'b1; frame_len = 16'd0; ifc.o_ready = 1'b1;
    cycle();
    start = 1'b0;
    check("len0_done", {63'd0, done}, 64'd1);
    check("len0_busy", {63'd0, busy}, 64'd1);
    check("len0_fifo_rd", {63'd0, ifc.fifo_rd}, 64'd0);
    check("len0_o_valid", {63'd0, ifc.o_valid}, 64'd0);
    cycle();
    check("len0_done_clear", {63'd0, done}, 64'd0);
    check("len0_idle", {63'd0, busy}, 64'd0);
    fifo_flush = 1'b1;
    cycle();
    fifo_flush = 1'b0;
    check("len0_no_pops", pops, 64'd0);

    // Reset after two of five words delivered.
    v = '{16'd5, 1'b0, 0, 0, -1, 16'd0, 1'b0, 20'h00400, 20'h10, 16'd5, 20'h00440, 1'b0};
    load_frame(v);
    pops = 0; beats = 0; last_beat = 1'b0;
    start = 1'b1; frame_len = v.len; ifc.o_ready = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 20 && beats < 2; c++) cycle();
    check("mid_beats_before_reset", beats, 64'd2);
    reset = 1'b1; ifc.o_ready = 1'b0; fifo_flush = 1'b1;
    cycle();
    reset = 1'b0; fifo_flush = 1'b0;
    check("mid_rst_o_valid", {63'd0, ifc.o_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_word_cnt", {48'd0, word_cnt}, 64'd0);
    check("mid_rst_fifo_rd", {63'd0, ifc.fifo_rd}, 64'd0);
    check("mid_rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    exp_q.delete();
    prev_valid = 1'b0; prev_pop = 1'b0;

    v = '{16'd3, 1'b0, 0, 0, -1, 16'd0, 1'b0, 20'h00700, 20'h01, 16'd3, 20'h00702, 1'b0};
    run_frame(v);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
